// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory bus bundle for load_store_unit
interface load_store_unit_if;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        signed_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rdata_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_data_i;

  modport slave (
    input  req_i, we_i, size_i, signed_i, addr_i, wdata_i, mem_data_i,
    output busy_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );

  modport master (
    output req_i, we_i, size_i, signed_i, addr_i, wdata_i, mem_data_i,
    input  busy_o, done_o, err_o, rdata_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - FSM-sequenced load/store unit with range/alignment checking
// Macro LSU_SUBWORD_EN adds byte/half accesses (lane extract, read-modify-write stores).
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  load_store_unit_if.slave lsu
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [1:0]  SZ_WORD   = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] load_word;
  logic [32:0] acc_bytes;
  logic        size_ok, align_ok, req_err;
  logic        rd_en, wr_en;
`ifdef LSU_SUBWORD_EN
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merge_word;
`else
  logic [31:2] addr_q;
`endif

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap past the limit.
  always_comb begin
    acc_bytes = 33'd4;
    size_ok   = 1'b1;
    align_ok  = 1'b1;
    case (lsu.size_i)
`ifdef LSU_SUBWORD_EN
      2'b00: acc_bytes = 33'd1;
      2'b01: begin
        acc_bytes = 33'd2;
        align_ok  = !lsu.addr_i[0];
      end
`endif
      SZ_WORD: align_ok = (lsu.addr_i[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
    req_err = !size_ok || !align_ok || (({1'b0, lsu.addr_i} + acc_bytes) > MEM_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lsu.req_i) begin
          if (req_err)                   state_d = DONE;
          else if (!lsu.we_i)            state_d = READ;
`ifdef LSU_SUBWORD_EN
          else if (lsu.size_i == SZ_WORD) state_d = WRITE;
          else                           state_d = READ;
`else
          else                           state_d = WRITE;
`endif
        end
      end
`ifdef LSU_SUBWORD_EN
      READ:    state_d = we_q ? WRITE : DONE;
`else
      READ:    state_d = DONE;
`endif
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  always_comb begin
    lane_b = lsu.mem_data_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h = lsu.mem_data_i[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_word = {{24{signed_q & lane_b[7]}}, lane_b};
      2'b01:   load_word = {{16{signed_q & lane_h[15]}}, lane_h};
      default: load_word = lsu.mem_data_i;
    endcase
    merge_word = lsu.mem_data_i;
    if (size_q == 2'b00) merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                 merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
`else
  assign load_word = lsu.mem_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
`ifdef LSU_SUBWORD_EN
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (lsu.req_i) begin
            wdata_q <= lsu.wdata_i;
`ifdef LSU_SUBWORD_EN
            addr_q   <= lsu.addr_i;
            we_q     <= lsu.we_i;
            size_q   <= lsu.size_i;
            signed_q <= lsu.signed_i;
`else
            addr_q   <= lsu.addr_i[31:2];
`endif
            if (req_err) err_q <= 1'b1;
          end
        end
        READ: begin
`ifdef LSU_SUBWORD_EN
          // A store passing through READ is the first half of a read-modify-write.
          if (we_q) begin
            wdata_q <= merge_word;
          end else begin
            rdata_q <= load_word;
            err_q   <= 1'b0;
          end
`else
          rdata_q <= load_word;
          err_q   <= 1'b0;
`endif
        end
        WRITE:   err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Enables are gated by reset so a write cannot commit on a reset edge.
  always_comb begin
    rd_en          = (state_q == READ) && !rst_i;
    wr_en          = (state_q == WRITE) && !rst_i;
    lsu.mem_read_o  = rd_en;
    lsu.mem_write_o = wr_en;
    lsu.mem_addr_o  = (rd_en || wr_en) ? {addr_q[31:2], 2'b00} : 32'd0;
    lsu.mem_data_o  = wr_en ? wdata_q : 32'd0;
  end

  assign lsu.busy_o  = (state_q != IDLE);
  assign lsu.done_o  = (state_q == DONE);
  assign lsu.err_o   = err_q;
  assign lsu.rdata_o = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit (vector table, byte-array reference model)
module tb_load_store_unit;
  localparam int MEM_BYTES = 128;
`ifdef LSU_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_clear = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (.clk_i(clk), .rst_i(rst), .lsu(bus));

  logic [31:0] env_mem [0:31];
  assign bus.mem_data_i = env_mem[bus.mem_addr_o[6:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= '0;
    end else if (bus.mem_write_o) begin
      env_mem[bus.mem_addr_o[6:2]] <= bus.mem_data_o;
    end
  end

  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [31:0] model_rdata;
  int asserts = 0;
  int fails = 0;
  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input int lat, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.err = err; v.lat = lat; v.rdata = rdata;
    return v;
  endfunction

  // Reference: memory is a flat byte array, accesses are plain little-endian byte loops.
  task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic err, output int lat, output logic [31:0] rdata);
    int nbytes;
    logic [31:0] v;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    err = (nbytes == 0) || (!SUB && nbytes != 4) || ((addr % nbytes) != 0) ||
          (longint'(addr) + nbytes > MEM_BYTES);
    if (err) begin
      lat = 1;
    end else if (!we) begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
      if (nbytes < 4 && sgn && v[8 * nbytes - 1]) v = v | ~((32'd1 << (8 * nbytes)) - 1);
      model_rdata = v;
      lat = 2;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[addr + i] = wdata[8 * i +: 8];
      lat = (nbytes == 4) ? 2 : 3;
    end
    rdata = model_rdata;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy_o) check("idle_timeout", {31'd0, bus.busy_o}, 32'd0);
  endtask

  task automatic run_access(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic exp_err, input int exp_lat, input logic [31:0] exp_rdata);
    int n, rd, wr;
    logic bus_ok, done_seen;
    wait_idle();
    bus.req_i = 1'b1; bus.we_i = we; bus.size_i = size; bus.signed_i = sgn;
    bus.addr_i = addr; bus.wdata_i = wdata;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    n = 0; rd = 0; wr = 0; bus_ok = 1'b1; done_seen = 1'b0;
    while (!done_seen && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.mem_read_o) rd++;
      if (bus.mem_write_o) wr++;
      if (bus.mem_read_o && bus.mem_write_o) bus_ok = 1'b0;
      if (!bus.mem_read_o && !bus.mem_write_o && (bus.mem_addr_o != 0 || bus.mem_data_o != 0)) bus_ok = 1'b0;
      done_seen = bus.done_o;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_err"}, {31'd0, bus.err_o}, {31'd0, exp_err});
    check({tag, "_rdata"}, bus.rdata_o, exp_rdata);
    check({tag, "_reads"}, 32'(rd), (!exp_err && (!we || exp_lat == 3)) ? 32'd1 : 32'd0);
    check({tag, "_writes"}, 32'(wr), (!exp_err && we) ? 32'd1 : 32'd0);
    check({tag, "_idle_bus"}, {31'd0, bus_ok}, 32'd1);
  endtask

  initial begin
    logic e;
    int l;
    logic [31:0] r, a, w, exp_w;
    logic [1:0] sz;
    logic wre, sg;
    logic done_seen;
    int acc[$];

    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'b10; bus.signed_i = 1'b0;
    bus.addr_i = 32'h0; bus.wdata_i = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    model_rdata = 32'h0;

    // Reset held with a pending request: reset must win.
    repeat (3) @(negedge clk);
    check("rst_gates_read", {31'd0, bus.mem_read_o}, 32'd0);
    rst = 1'b0; mem_clear = 1'b0; bus.req_i = 1'b0;
    check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset_done", {31'd0, bus.done_o}, 32'd0);
    check("reset_err", {31'd0, bus.err_o}, 32'd0);
    check("reset_rdata", bus.rdata_o, 32'd0);
    check("reset_mem_addr", bus.mem_addr_o, 32'd0);
    @(negedge clk);
    check("reset_idle_after", {31'd0, bus.busy_o}, 32'd0);

    vt[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 2, 32'h0);
    vt[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 2, 32'hDEADBEEF);
    vt[2]  = mk(1, 2'b00, 0, 32'h11, 32'h000000AA, !SUB, SUB ? 3 : 1, 32'hDEADBEEF);
    vt[3]  = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 2, SUB ? 32'hDEADAAEF : 32'hDEADBEEF);
    vt[4]  = mk(0, 2'b00, 1, 32'h11, 32'h0, !SUB, SUB ? 2 : 1, SUB ? 32'hFFFFFFAA : 32'hDEADBEEF);
    vt[5]  = mk(0, 2'b00, 0, 32'h11, 32'h0, !SUB, SUB ? 2 : 1, SUB ? 32'h000000AA : 32'hDEADBEEF);
    vt[6]  = mk(0, 2'b10, 0, 32'h12, 32'h0, 1, 1, SUB ? 32'h000000AA : 32'hDEADBEEF);
    vt[7]  = mk(1, 2'b10, 0, 32'h7C, 32'h12345678, 0, 2, SUB ? 32'h000000AA : 32'hDEADBEEF);
    vt[8]  = mk(0, 2'b10, 0, 32'h7C, 32'h0, 0, 2, 32'h12345678);
    vt[9]  = mk(0, 2'b10, 0, 32'h80, 32'h0, 1, 1, 32'h12345678);
    vt[10] = mk(0, 2'b11, 0, 32'h10, 32'h0, 1, 1, 32'h12345678);
    vt[11] = mk(0, 2'b01, 0, 32'h13, 32'h0, 1, 1, 32'h12345678);
    vt[12] = mk(1, 2'b01, 0, 32'h12, 32'h0000BEEF, !SUB, SUB ? 3 : 1, 32'h12345678);
    vt[13] = mk(0, 2'b01, 1, 32'h12, 32'h0, !SUB, SUB ? 2 : 1, SUB ? 32'hFFFFBEEF : 32'h12345678);
    vt[14] = mk(0, 2'b00, 0, 32'h7F, 32'h0, !SUB, SUB ? 2 : 1, SUB ? 32'h00000012 : 32'h12345678);
    vt[15] = mk(0, 2'b00, 0, 32'h80, 32'h0, 1, 1, SUB ? 32'h00000012 : 32'h12345678);
    vt[16] = mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 2, SUB ? 32'hBEEFAAEF : 32'hDEADBEEF);

    for (int i = 0; i < 17; i++) begin
      model_access(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, e, l, r);
      run_access($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata,
                 vt[i].err, vt[i].lat, vt[i].rdata);
    end

    // Reset arriving in the WRITE cycle of a word store to 0x20.
    wait_idle();
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.size_i = 2'b10; bus.addr_i = 32'h20; bus.wdata_i = 32'h55AA55AA;
    @(posedge clk);
    #1 bus.req_i = 1'b0;
    @(negedge clk);
    check("rstw_write_phase", {31'd0, bus.mem_write_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstw_enables_gated", {30'd0, bus.mem_write_o, bus.mem_read_o}, 32'd0);
    check("rstw_bus_zero", bus.mem_addr_o | bus.mem_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rstw_rdata_cleared", bus.rdata_o, 32'd0);
    done_seen = bus.done_o;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | bus.done_o;
    end
    check("rstw_no_done", {31'd0, done_seen}, 32'd0);
    check("rstw_mem_unchanged", env_mem[8], {ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]});
    model_rdata = 32'h0;

    // Request held high: accepts must come every 3 cycles for word loads.
    wait_idle();
    model_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, l, r);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'b10; bus.signed_i = 1'b0; bus.addr_i = 32'h10;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (!bus.busy_o) acc.push_back(i);
    end
    bus.req_i = 1'b0;
    check("held_accept_count", 32'(acc.size()), 32'd5);
    for (int k = 1; k < acc.size(); k++) check($sformatf("held_spacing%0d", k), 32'(acc[k] - acc[k-1]), 32'd3);
    wait_idle();
    check("held_rdata", bus.rdata_o, r);

    // Random accesses against the byte-array model.
    for (int i = 0; i < 250; i++) begin
      wre = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      w   = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = 32'($urandom_range(0, 33)) * 4 +
            ((sz == 2'd0) ? 32'($urandom_range(0, 3)) : (sz == 2'd1) ? 32'($urandom_range(0, 1)) * 2 : 32'd0);
      else
        a = 32'($urandom_range(0, 140));
      model_access(wre, sz, sg, a, w, e, l, r);
      run_access($sformatf("rnd%0d", i), wre, sz, sg, a, w, e, l, r);
    end

    for (int i = 0; i < 32; i++) begin
      exp_w = {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
      check($sformatf("final_mem%0d", i), env_mem[i], exp_w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 128, meaning the data memory size in bytes used for the range check.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req_i, input, 1, access request, sampled only in IDLE.
REQ-005 SHALL have port we_i, input, 1, where 1 = store and 0 = load.
REQ-006 SHALL have port size_i, input, 2, where 00 = byte, 01 = half, 10 = word and 11 = illegal.
REQ-007 SHALL have port signed_i, input, 1, sign-extend sub-word loads when 1 and zero-extend when 0.
REQ-008 SHALL have port addr_i, input, 32, byte address.
REQ-009 SHALL have port wdata_i, input, 32, store data right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-011 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err_o, output, 1, error flag valid with done_o and held until the next completion.
REQ-013 SHALL have port rdata_o, output, 32, extended load result, held until the next successful load completes.
REQ-014 SHALL have port mem_addr_o, output, 32, word-aligned memory address ({addr[31:2],2'b00}).
REQ-015 SHALL have port mem_data_o, output, 32, memory write word.
REQ-016 SHALL have port mem_read_o, output, 1, memory read enable.
REQ-017 SHALL have port mem_write_o, output, 1, memory write enable; the memory commits the write on the clk_i edge ending the cycle.
REQ-018 SHALL have port mem_data_i, input, 32, memory read word, combinationally valid in the same cycle as mem_read_o.

Function
REQ-019 SHALL latch we_i, size_i, signed_i, addr_i and wdata_i on the edge that accepts a request (IDLE and req_i=1); req_i in other states SHALL be ignored.
REQ-020 SHALL implement the states IDLE, READ, WRITE and DONE, with DONE always returning to IDLE.
REQ-021 SHALL sequence a load as IDLE -> READ -> DONE, with mem_read_o=1 in READ and mem_data_i captured on the READ exit edge; done_o is asserted 2 cycles after acceptance.
REQ-022 SHALL sequence a word store as IDLE -> WRITE -> DONE, with mem_write_o=1 and mem_data_o=wdata in WRITE; done_o is asserted 2 cycles after acceptance.
REQ-023 SHALL sequence a byte/half store as the read-modify-write IDLE -> READ -> WRITE -> DONE: the read word is captured, only the target lanes are replaced and the merged word is written; done_o is asserted 3 cycles after acceptance.
REQ-024 SHALL use little-endian lane selection: byte lane = addr[1:0]; half lane = addr[1] (lanes [15:0] or [31:16]).
REQ-025 SHALL extend a load result as follows: byte/half selected lane sign-extended when signed_i=1 and zero-extended otherwise; word passed unchanged.
REQ-026 SHALL treat as errors: a half with addr[0]=1, a word with addr[1:0]!=0, size_i=11, or addr+access_bytes > MEM_BYTES.
REQ-027 SHALL, on error, go IDLE -> DONE with err_o=1, no mem_read_o or mem_write_o asserted and rdata_o unchanged.
REQ-028 SHALL clear err_o to 0 on a successful completion.
REQ-029 SHALL drive mem_read_o and mem_write_o high only in their respective states, never simultaneously.
REQ-030 SHALL drive mem_addr_o and mem_data_o to 0 whenever no memory enable is high.
REQ-031 SHALL allow a new request to be accepted at the earliest in the IDLE cycle following DONE (the minimum request spacing is 3 cycles for a word access).

Reset
REQ-032 SHALL, with rst_i=1 at an edge, enter IDLE and set busy_o=0, done_o=0, err_o=0 and rdata_o=0.
REQ-033 SHALL force mem_read_o, mem_write_o, mem_addr_o and mem_data_o to 0 combinationally in any cycle with rst_i=1, so that no write commits during reset.
REQ-034 SHALL, on reset mid-operation (any state), abandon the access without completing it and assert no done_o for it.
REQ-035 SHALL let reset take priority over a simultaneous req_i.

Configuration
REQ-036 SHALL, with macro LSU_SUBWORD_EN defined, support byte and half accesses as in REQ-023 to REQ-025.
REQ-037 SHALL, without LSU_SUBWORD_EN, treat size_i other than 10 as an error (REQ-027) and omit the READ-before-WRITE path and the lane merge logic.

Verification
REQ-038 SHALL cover a word store: addr=0x10, wdata=0xDEADBEEF -> mem_write_o for 1 cycle at 0x10; a following word load at 0x10 -> rdata_o=0xDEADBEEF, done_o 2 cycles after acceptance.
REQ-039 SHALL cover a byte store: addr=0x11, wdata=0x000000AA, memory word 0xDEADBEEF -> memory word becomes 0xDEADAAEF; done_o 3 cycles after acceptance.
REQ-040 SHALL cover sign extension: a byte load at 0x11 with signed_i=1 -> rdata_o=0xFFFFFFAA, and with signed_i=0 -> rdata_o=0x000000AA.
REQ-041 SHALL cover errors: a word load at 0x12 -> err_o=1, no memory enable asserted, rdata_o unchanged; a word load at 0x7C -> ok; a word load at 0x80 -> err_o=1.
REQ-042 SHALL cover reset in WRITE: rst_i=1 in the WRITE cycle of a store to 0x20 -> memory at 0x20 unchanged, busy_o=0 and no done_o.
REQ-043 SHALL cover a held request: req_i held high throughout -> accepts spaced exactly at the REQ-031 minimum, busy_o never high in an accept cycle.
